multi_alarm_clock_core: RTL

MULTI_ALARM_CLOCK_CORE -- requirements
Module: multi_alarm_clock_core

---
 rtl/multi_alarm_clock_core.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_alarm_clock_core.sv
// Multi-alarm clock core: 24h time base with a second prescaler, 12/24h display and load
// conversion, NUM_ALARMS alarm registers and an IDLE/RING/SNOOZE ring state machine.
module multi_alarm_clock_core #(
  parameter int CLK_PER_SEC = 64,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SECS   = 60,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  fpgaGlobalClock,
  input  logic                  n_Reset,
  input  logic                  Mode24,
  input  logic [5:0]            D_hours,
  input  logic [5:0]            D_Mins,
  input  logic [5:0]            D_secs,
  input  logic                  AM_PM,
  input  logic                  LoadTime,
  input  logic                  LoadAlarm,
  input  logic [SEL_W-1:0]      AlarmSel,
  input  logic [NUM_ALARMS-1:0] AlarmEnable,
  input  logic                  Snooze,
  input  logic                  Stop,
  output logic [5:0]            Hours,
  output logic [5:0]            Mins,
  output logic [5:0]            Secs,
  output logic                  PM,
  output logic                  SecTick,
  output logic                  Ringing,
  output logic [SEL_W-1:0]      RingId,
  output logic                  LoadErr
);

  localparam int PRE_W = $clog2(CLK_PER_SEC);
  localparam int SNZ_W = 12;
  localparam int RNG_W = 8;
  localparam logic [SEL_W:0] NUM_A_W = (SEL_W + 1)'(NUM_ALARMS);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  logic [PRE_W-1:0] r_presc;
  logic [4:0]       r_h24;
  logic [5:0]       r_min, r_sec;
  logic [4:0]       r_al_h [NUM_ALARMS];
  logic [5:0]       r_al_m [NUM_ALARMS];
  logic [5:0]       r_hours, r_mins, r_secs;
  logic             r_pm, r_sectick, r_loaderr;
  state_t           r_state;
  logic [RNG_W-1:0] r_ring_cnt;
  logic [SNZ_W-1:0] r_snz_cnt;
  logic [SEL_W-1:0] r_ringid;

  logic [PRE_W-1:0] w_presc_nxt;
  logic [4:0]       w_h_nxt;
  logic [5:0]       w_m_nxt, w_s_nxt;
  logic             w_time_ok, w_alarm_ok, w_time_ld, w_wrap, w_tick, w_eval;
  logic             w_match, w_sel_en;
  logic [SEL_W-1:0] w_match_id, w_ringid_nxt;
  state_t           w_state_nxt;
  logic [RNG_W-1:0] w_ring_cnt_nxt;
  logic [SNZ_W-1:0] w_snz_nxt;

  function automatic logic f_hour_ok(logic [5:0] dh, logic m24);
    return m24 ? (dh <= 6'd23) : (dh >= 6'd1 && dh <= 6'd12);
  endfunction

  // 12h load: 12 AM is hour 0, PM adds 12 (so 12 PM lands on 12)
  function automatic logic [4:0] f_to_h24(logic [5:0] dh, logic m24, logic ampm);
    logic [4:0] base;
    if (m24) return dh[4:0];
    base = (dh == 6'd12) ? 5'd0 : dh[4:0];
    return ampm ? base + 5'd12 : base;
  endfunction

  function automatic logic [5:0] f_disp_hours(logic [4:0] h24, logic m24);
    if (m24) return {1'b0, h24};
    if (h24 == 5'd0) return 6'd12;
    if (h24 > 5'd12) return {1'b0, h24 - 5'd12};
    return {1'b0, h24};
  endfunction

  function automatic logic f_disp_pm(logic [4:0] h24, logic m24);
    return !m24 && (h24 >= 5'd12);
  endfunction

  assign w_time_ok  = f_hour_ok(D_hours, Mode24) && (D_Mins <= 6'd59) && (D_secs <= 6'd59);
  assign w_alarm_ok = f_hour_ok(D_hours, Mode24) && (D_Mins <= 6'd59) && ({1'b0, AlarmSel} < NUM_A_W);
  assign w_time_ld  = LoadTime && w_time_ok;
  assign w_wrap     = (r_presc == PRE_W'(CLK_PER_SEC - 1));
  assign w_tick     = w_wrap && !w_time_ld;
  assign w_eval     = (w_tick || w_time_ld) && (w_s_nxt == 6'd0);

  always_comb begin
    w_presc_nxt = w_wrap ? '0 : r_presc + PRE_W'(1);
    w_h_nxt     = r_h24;
    w_m_nxt     = r_min;
    w_s_nxt     = r_sec;
    if (w_time_ld) begin
      w_presc_nxt = '0;
      w_h_nxt     = f_to_h24(D_hours, Mode24, AM_PM);
      w_m_nxt     = D_Mins;
      w_s_nxt     = D_secs;
    end else if (w_tick) begin
      if (r_sec == 6'd59) begin
        w_s_nxt = 6'd0;
        if (r_min == 6'd59) begin
          w_m_nxt = 6'd0;
          w_h_nxt = (r_h24 == 5'd23) ? 5'd0 : r_h24 + 5'd1;
        end else begin
          w_m_nxt = r_min + 6'd1;
        end
      end else begin
        w_s_nxt = r_sec + 6'd1;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_match    = 1'b0;
    w_match_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_eval && AlarmEnable[i] && r_al_h[i] == w_h_nxt && r_al_m[i] == w_m_nxt) begin
        w_match    = 1'b1;
        w_match_id = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_en = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (r_ringid == SEL_W'(i)) w_sel_en = AlarmEnable[i];
    end
  end

  always_ff @(posedge fpgaGlobalClock) begin
    if (!n_Reset) begin
      r_presc   <= '0;
      r_h24     <= 5'd0;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_hours   <= Mode24 ? 6'd0 : 6'd12;
      r_mins    <= 6'd0;
      r_secs    <= 6'd0;
      r_pm      <= 1'b0;
      r_sectick <= 1'b0;
      r_loaderr <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_h[i] <= 5'd0;
        r_al_m[i] <= 6'd0;
      end
    end else begin
      r_presc   <= w_presc_nxt;
      r_h24     <= w_h_nxt;
      r_min     <= w_m_nxt;
      r_sec     <= w_s_nxt;
      r_hours   <= f_disp_hours(w_h_nxt, Mode24);
      r_mins    <= w_m_nxt;
      r_secs    <= w_s_nxt;
      r_pm      <= f_disp_pm(w_h_nxt, Mode24);
      r_sectick <= w_tick;
      r_loaderr <= (LoadTime && !w_time_ok) || (LoadAlarm && !w_alarm_ok);
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (LoadAlarm && w_alarm_ok && AlarmSel == SEL_W'(i)) begin
          r_al_h[i] <= f_to_h24(D_hours, Mode24, AM_PM);
          r_al_m[i] <= D_Mins;
        end
      end
    end
  end

  // Ring state machine: Stop outranks Snooze; matches only start a ring from IDLE
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_nxt      = r_snz_cnt;
    w_ringid_nxt   = r_ringid;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_nxt    = ST_RING;
          w_ring_cnt_nxt = '0;
          w_ringid_nxt   = w_match_id;
        end
      end
      ST_RING: begin
        if (Stop) begin
          w_state_nxt = ST_IDLE;
        end else if (Snooze) begin
          w_state_nxt = ST_SNOOZE;
          w_snz_nxt   = SNZ_W'(SNOOZE_MIN * 60);
        end else if (w_tick) begin
          if (r_ring_cnt == RNG_W'(RING_SECS - 1)) w_state_nxt = ST_IDLE;
          else w_ring_cnt_nxt = r_ring_cnt + RNG_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (Stop || !w_sel_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_snz_cnt <= SNZ_W'(1)) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = '0;
          end else begin
            w_snz_nxt = r_snz_cnt - SNZ_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fpgaGlobalClock) begin
    if (!n_Reset) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_ringid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_ringid   <= w_ringid_nxt;
    end
  end

  assign Hours   = r_hours;
  assign Mins    = r_mins;
  assign Secs    = r_secs;
  assign PM      = r_pm;
  assign SecTick = r_sectick;
  assign LoadErr = r_loaderr;
  assign Ringing = (r_state == ST_RING);
  assign RingId  = r_ringid;

endmodule
